jace_ps2_keyboard: RTL and testbench

JACE_PS2_KEYBOARD -- requirements
Module: jace_ps2_keyboard

---
 rtl/jace_kbd_pkg.sv | 55 +++++
 rtl/jace_scancode_map.sv | 88 ++++++++
 rtl/jace_ps2_keyboard.sv | 215 +++++++++++++++++++++
 tb/tb_jace_ps2_keyboard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jace_kbd_pkg.sv
// Shared constants and types for the Jupiter Ace PS/2 keyboard front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds matrix row/column indices, PS/2 prefix codes, the default
// partial-frame timeout, the receiver state type and the key position record.
package jace_kbd_pkg;

  localparam int TIMEOUT_DEFAULT = 50000;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  // Matrix rows; named after the keys they carry, bit 0 first
  localparam logic [2:0] ROW_SHIFT_C = 3'd0;  // Shift SymShift Z X C
  localparam logic [2:0] ROW_A_G     = 3'd1;  // A S D F G
  localparam logic [2:0] ROW_Q_T     = 3'd2;  // Q W E R T
  localparam logic [2:0] ROW_1_5     = 3'd3;  // 1 2 3 4 5
  localparam logic [2:0] ROW_0_6     = 3'd4;  // 0 9 8 7 6
  localparam logic [2:0] ROW_P_Y     = 3'd5;  // P O I U Y
  localparam logic [2:0] ROW_ENT_H   = 3'd6;  // Enter L K J H
  localparam logic [2:0] ROW_SPC_V   = 3'd7;  // Space M N B V

  localparam logic [2:0] COL_0 = 3'd0;
  localparam logic [2:0] COL_1 = 3'd1;
  localparam logic [2:0] COL_2 = 3'd2;
  localparam logic [2:0] COL_3 = 3'd3;
  localparam logic [2:0] COL_4 = 3'd4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t key_at(input logic [2:0] row, input logic [2:0] col);
    key_pos_t p;
    p.vld = 1'b1;
    p.row = row;
    p.col = col;
    return p;
  endfunction

endpackage

// File: rtl/jace_scancode_map.sv
// Translates a PS/2 set-2 scancode (plus E0 prefix flag) to a Jupiter Ace matrix position.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed on the cycle it is presented.
//
// Ports: code[7:0] scancode, extended = E0 prefix seen,
//        valid = code maps to a key, row[2:0]/col[2:0] = matrix position.
// Macro JACE_KEYB_CURSOR_EN: E0 arrows map onto the digits 5/6/7/8 and right Ctrl
// onto SymShift; when undefined every extended code is unmapped.
module jace_scancode_map
  import jace_kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       extended,
  output logic       valid,
  output logic [2:0] row,
  output logic [2:0] col
);

  key_pos_t pos;

  always_comb begin
    pos = '0;
    if (!extended) begin
      case (code)
        8'h12, 8'h59: pos = key_at(ROW_SHIFT_C, COL_0);  // left/right Shift
        8'h14:        pos = key_at(ROW_SHIFT_C, COL_1);  // left Ctrl -> SymShift
        8'h1A:        pos = key_at(ROW_SHIFT_C, COL_2);
        8'h22:        pos = key_at(ROW_SHIFT_C, COL_3);
        8'h21:        pos = key_at(ROW_SHIFT_C, COL_4);
        8'h1C:        pos = key_at(ROW_A_G, COL_0);
        8'h1B:        pos = key_at(ROW_A_G, COL_1);
        8'h23:        pos = key_at(ROW_A_G, COL_2);
        8'h2B:        pos = key_at(ROW_A_G, COL_3);
        8'h34:        pos = key_at(ROW_A_G, COL_4);
        8'h15:        pos = key_at(ROW_Q_T, COL_0);
        8'h1D:        pos = key_at(ROW_Q_T, COL_1);
        8'h24:        pos = key_at(ROW_Q_T, COL_2);
        8'h2D:        pos = key_at(ROW_Q_T, COL_3);
        8'h2C:        pos = key_at(ROW_Q_T, COL_4);
        8'h16:        pos = key_at(ROW_1_5, COL_0);
        8'h1E:        pos = key_at(ROW_1_5, COL_1);
        8'h26:        pos = key_at(ROW_1_5, COL_2);
        8'h25:        pos = key_at(ROW_1_5, COL_3);
        8'h2E:        pos = key_at(ROW_1_5, COL_4);
        8'h45:        pos = key_at(ROW_0_6, COL_0);
        8'h46:        pos = key_at(ROW_0_6, COL_1);
        8'h3E:        pos = key_at(ROW_0_6, COL_2);
        8'h3D:        pos = key_at(ROW_0_6, COL_3);
        8'h36:        pos = key_at(ROW_0_6, COL_4);
        8'h4D:        pos = key_at(ROW_P_Y, COL_0);
        8'h44:        pos = key_at(ROW_P_Y, COL_1);
        8'h43:        pos = key_at(ROW_P_Y, COL_2);
        8'h3C:        pos = key_at(ROW_P_Y, COL_3);
        8'h35:        pos = key_at(ROW_P_Y, COL_4);
        8'h5A:        pos = key_at(ROW_ENT_H, COL_0);
        8'h4B:        pos = key_at(ROW_ENT_H, COL_1);
        8'h42:        pos = key_at(ROW_ENT_H, COL_2);
        8'h3B:        pos = key_at(ROW_ENT_H, COL_3);
        8'h33:        pos = key_at(ROW_ENT_H, COL_4);
        8'h29:        pos = key_at(ROW_SPC_V, COL_0);
        8'h3A:        pos = key_at(ROW_SPC_V, COL_1);
        8'h31:        pos = key_at(ROW_SPC_V, COL_2);
        8'h32:        pos = key_at(ROW_SPC_V, COL_3);
        8'h2A:        pos = key_at(ROW_SPC_V, COL_4);
        default:      pos = '0;
      endcase
    end
`ifdef JACE_KEYB_CURSOR_EN
    else begin
      // Arrows land on their digit position; the top diverts any extended
      // hit outside row 0 into the virtual cursor matrix.
      case (code)
        8'h14:   pos = key_at(ROW_SHIFT_C, COL_1);  // right Ctrl -> SymShift
        8'h6B:   pos = key_at(ROW_1_5, COL_4);      // left  -> 5
        8'h72:   pos = key_at(ROW_0_6, COL_4);      // down  -> 6
        8'h75:   pos = key_at(ROW_0_6, COL_3);      // up    -> 7
        8'h74:   pos = key_at(ROW_0_6, COL_2);      // right -> 8
        default: pos = '0;
      endcase
    end
`endif
  end

  assign valid = pos.vld;
  assign row   = pos.row;
  assign col   = pos.col;

endmodule

// File: rtl/jace_ps2_keyboard.sv
// PS/2 keyboard receiver feeding a Jupiter Ace 8x5 key matrix read through filas/columnas.
// Latency: scan_strobe one clk after the synchronised stop-bit edge; matrix visible the cycle after.
// Backpressure: none; the keyboard cannot be stalled, bad or stalled frames are dropped.
//
// Ports: clk, reset (async, active-low), ps2clk/ps2data (raw, asynchronous),
//        filas[7:0] (A15..A8, 0 selects a row), columnas[4:0] (active-low keys),
//        scan_strobe (one pulse per accepted byte).
// Macro JACE_KEYB_CURSOR_EN: enables E0 arrow keys as Shift+5/6/7/8 via a virtual matrix.
module jace_ps2_keyboard
  import jace_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] filas,
  output logic [4:0] columnas,
  output logic       scan_strobe
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- sync
  logic [1:0] ps2clk_sync, ps2data_sync;
  logic       ps2clk_d;
  logic       ps2clk_s, ps2data_s, ps2_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2clk_sync  <= 2'b11;
      ps2data_sync <= 2'b11;
      ps2clk_d     <= 1'b1;
    end else begin
      ps2clk_sync  <= {ps2clk_sync[0], ps2clk};
      ps2data_sync <= {ps2data_sync[0], ps2data};
      ps2clk_d     <= ps2clk_s;
    end
  end

  assign ps2clk_s  = ps2clk_sync[1];
  assign ps2data_s = ps2data_sync[1];
  assign ps2_fall  = ps2clk_d & ~ps2clk_s;

  // ------------------------------------------------------- frame timeout
  // Counts clk cycles since the last ps2clk falling edge, saturating.
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         tmo_cnt_q <= '0;
    else if (ps2_fall)  tmo_cnt_q <= '0;
    else if (!tmo_hit)  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  // ------------------------------------------------------------ receiver
  rx_state_t  state_q, state_nxt;
  logic [7:0] sr_q, sr_nxt;
  logic [2:0] bcnt_q, bcnt_nxt;
  logic       par_q, par_nxt;
  logic       frame_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sr_q    <= sr_nxt;
      bcnt_q  <= bcnt_nxt;
      par_q   <= par_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    sr_nxt    = sr_q;
    bcnt_nxt  = bcnt_q;
    par_nxt   = par_q;
    frame_ok  = 1'b0;
    if (ps2_fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!ps2data_s) begin
            state_nxt = RX_SHIFT;
            bcnt_nxt  = '0;
          end
        end
        RX_SHIFT: begin
          sr_nxt   = {ps2data_s, sr_q[7:1]};  // LSB arrives first
          bcnt_nxt = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          par_nxt   = ps2data_s;
          state_nxt = RX_STOP;
        end
        RX_STOP: begin
          state_nxt = RX_IDLE;
          frame_ok  = ps2data_s & (^{sr_q, par_q});  // odd parity, stop = 1
        end
        default: state_nxt = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tmo_hit) begin
      state_nxt = RX_IDLE;
    end
  end

  // ------------------------------------------------------- byte + flags
  logic [7:0] byte_q;
  logic       strobe_q;
  logic       brk_q, ext_q;
  logic       map_vld;
  logic [2:0] map_row, map_col;
  logic       is_cursor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= frame_ok;
      if (frame_ok) byte_q <= sr_q;
    end
  end

  assign scan_strobe = strobe_q;

  jace_scancode_map u_map (
    .code     (byte_q),
    .extended (ext_q),
    .valid    (map_vld),
    .row      (map_row),
    .col      (map_col)
  );

  // Matrix is 1 = released, so a make writes 0 and a break writes 1.
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] mat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      mat_q <= '1;
    end else if (strobe_q) begin
      if (byte_q == CODE_BREAK) begin
        brk_q <= 1'b1;
      end else if (byte_q == CODE_EXT) begin
        ext_q <= 1'b1;
      end else begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
        if (map_vld && !is_cursor) mat_q[map_row][map_col] <= brk_q;
      end
    end
  end

  // ------------------------------------------------ virtual cursor keys
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] virt_rows;

`ifdef JACE_KEYB_CURSOR_EN
  logic [3:0] cur_q;  // left, down, up, right; 1 = released
  logic [1:0] cur_idx;

  always_comb begin
    is_cursor = ext_q && map_vld && (map_row != ROW_SHIFT_C);
    cur_idx   = 2'd0;
    if (map_row == ROW_0_6) begin
      case (map_col)
        COL_4:   cur_idx = 2'd1;
        COL_3:   cur_idx = 2'd2;
        default: cur_idx = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cur_q <= 4'hF;
    else if (strobe_q && byte_q != CODE_BREAK && byte_q != CODE_EXT && is_cursor)
      cur_q[cur_idx] <= brk_q;
  end

  // Any held arrow also holds Shift.
  always_comb begin
    virt_rows = '1;
    virt_rows[ROW_SHIFT_C][COL_0] = &cur_q;
    virt_rows[ROW_1_5][COL_4]     = cur_q[0];
    virt_rows[ROW_0_6][COL_4]     = cur_q[1];
    virt_rows[ROW_0_6][COL_3]     = cur_q[2];
    virt_rows[ROW_0_6][COL_2]     = cur_q[3];
  end
`else
  assign is_cursor = 1'b0;
  assign virt_rows = '1;
`endif

  // ---------------------------------------------------------- read port
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] eff_rows;

  assign eff_rows = mat_q & virt_rows;

  always_comb begin
    columnas = '1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!filas[r]) columnas = columnas & eff_rows[r];
    end
  end

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Randomised + directed bench for jace_ps2_keyboard against a key-table reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_jace_ps2_keyboard;

  localparam int TO   = 300;  // short timeout keeps the run brief
  localparam int HALF = 10;   // ps2clk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] filas;
  logic [4:0] columnas;
  logic       scan_strobe;

  int total = 0;
  int bad   = 0;
  int strobe_seen = 0;
  int exp_strobes = 0;

  always #5 clk = ~clk;

  jace_ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .filas       (filas),
    .columnas    (columnas),
    .scan_strobe (scan_strobe)
  );

  always @(posedge clk) if (scan_strobe === 1'b1) strobe_seen <= strobe_seen + 1;

  // ------------------------------------------------------ reference model
  localparam logic [7:0] KEY_TAB [8][5] = '{
    '{8'h12, 8'h14, 8'h1A, 8'h22, 8'h21},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A}
  };
  localparam logic [7:0] ARROW_CODE [4] = '{8'h6B, 8'h72, 8'h75, 8'h74};
  localparam int         ARROW_ROW  [4] = '{3, 4, 4, 4};
  localparam int         ARROW_COL  [4] = '{4, 4, 3, 2};

  logic [4:0] m_mat [8];  // 1 = released
  logic       m_arrow [4];  // 1 = held
  logic       m_brk, m_ext;

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_mat[r] = 5'h1F;
    for (int k = 0; k < 4; k++) m_arrow[k] = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] key;
    exp_strobes++;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext) begin
        key = (b == 8'h59) ? 8'h12 : b;  // right Shift is Shift
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 5; c++)
            if (KEY_TAB[r][c] == key) m_mat[r][c] = m_brk;
      end else begin
`ifdef JACE_KEYB_CURSOR_EN
        if (b == 8'h14) m_mat[0][1] = m_brk;  // right Ctrl
        for (int k = 0; k < 4; k++)
          if (b == ARROW_CODE[k]) m_arrow[k] = !m_brk;
`endif
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  function automatic logic [4:0] exp_cols(input logic [7:0] f);
    logic [4:0] rows [8];
    logic [4:0] res;
    for (int r = 0; r < 8; r++) rows[r] = m_mat[r];
    for (int k = 0; k < 4; k++)
      if (m_arrow[k]) begin
        rows[0][0] = 1'b0;
        rows[ARROW_ROW[k]][ARROW_COL[k]] = 1'b0;
      end
    res = 5'h1F;
    for (int r = 0; r < 8; r++) if (!f[r]) res = res & rows[r];
    return res;
  endfunction

  // ---------------------------------------------------------- checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [7:0] f);
    @(negedge clk);
    filas = f;
    #1;
    check_eq(tag, 32'(columnas), 32'(exp_cols(f)));
  endtask

  // ---------------------------------------------------------- stimulus
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2data = b;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic par;
    par = (~^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2data = 1'b1;
    repeat (HALF + 4) @(negedge clk);
    if (!bad_par && !bad_stop) model_byte(code);
  endtask

  task automatic good(input logic [7:0] code);
    frame(code, 1'b0, 1'b0);
  endtask

  localparam logic [7:0] POOL [24] = '{
    8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h14, 8'h1A,
    8'h1C, 8'h2D, 8'h2E, 8'h36, 8'h3E, 8'h43, 8'h5A, 8'h29,
    8'h2A, 8'h6B, 8'h72, 8'h75, 8'h74, 8'h76, 8'h05, 8'h1C
  };

  initial begin
    reset   = 1'b0;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    filas   = 8'hFF;
    model_reset();
    repeat (5) @(negedge clk);
    probe("reset_cols", 8'h00);
    check_eq("reset_strobe", 32'(scan_strobe), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    probe("idle_ff", 8'hFF);

    // A pressed
    good(8'h1C);
    probe("a_make", 8'hFD);
    check_eq("a_strobes", strobe_seen, exp_strobes);

    // typematic repeat, then release
    good(8'h1C);
    probe("a_repeat", 8'hFD);
    good(8'hF0);
    good(8'h1C);
    probe("a_break", 8'hFD);
    check_eq("break_strobes", strobe_seen, exp_strobes);

    // bad parity and bad stop are dropped
    frame(8'h1C, 1'b1, 1'b0);
    check_eq("badpar_strobes", strobe_seen, exp_strobes);
    probe("badpar_cols", 8'hFD);
    frame(8'h1C, 1'b0, 1'b1);
    check_eq("badstop_strobes", strobe_seen, exp_strobes);
    probe("badstop_cols", 8'hFD);

    // partial frame abandoned by timeout
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2data = 1'b1;
    repeat (TO + 1) @(negedge clk);
    good(8'h29);
    probe("tmo_space", 8'h7F);
    check_eq("tmo_strobes", strobe_seen, exp_strobes);
    good(8'hF0);
    good(8'h29);

    // Shift + Z, then reset mid-frame
    good(8'h12);
    good(8'h1A);
    probe("shift_z_all", 8'h00);
    probe("shift_z_row0", 8'hFE);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    probe("rst_mid_cols", 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    probe("rst_after_cols", 8'h00);
    check_eq("rst_after_strobes", strobe_seen, exp_strobes);

    // extended codes
    good(8'hE0);
    good(8'h6B);
    probe("left_row0", 8'hFE);
    probe("left_row3", 8'hF7);
    probe("left_all", 8'h00);
    good(8'hE0);
    good(8'hF0);
    good(8'h6B);
    probe("left_rel", 8'h00);
    good(8'hE0);
    good(8'h14);
    probe("rctrl_row0", 8'hFE);
    good(8'hE0);
    good(8'hF0);
    good(8'h14);
    good(8'hE0);
    good(8'h1C);
    probe("ext_a_ignored", 8'hFD);
    check_eq("ext_strobes", strobe_seen, exp_strobes);

    // random traffic
    for (int n = 0; n < 45; n++) begin
      logic [7:0] code;
      logic       corrupt;
      code    = POOL[$urandom_range(0, 23)];
      corrupt = ($urandom_range(0, 7) == 0);
      frame(code, corrupt, 1'b0);
      check_eq("rnd_strobes", strobe_seen, exp_strobes);
      probe("rnd_all", 8'h00);
      probe("rnd_row", ~(8'h01 << $urandom_range(0, 7)));
      probe("rnd_filas", 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
